srambank_req_ctrl: RTL and testbench

Request/response front-end placed directly upstream of one `srambank_64x4x20_6t122` instance.
- Converts a valid/ready request stream (reads and writes) into the bank's single-cycle `banksel`/`read`/`write` pin protocol.
- Captures the bank's latched `dataout` one cycle after each read.
- Returns read data through a credit-controlled response FIFO, so a stalled consumer never loses data.
- Writes complete silently and return no response.

---
 rtl/srambank_pkg.sv | 23 ++
 rtl/srambank_req_ctrl_if.sv | 32 +++
 rtl/srambank_resp_fifo.sv | 66 ++++++
 rtl/srambank_req_ctrl.sv | 73 +++++++
 tb/tb_srambank_req_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srambank_pkg.sv
// srambank_pkg
//   Shared constants and the request record for the srambank request
//   controller slice. Default sizes match one srambank_64x4x20_6t122 bank:
//   256 words of 20 bits, two response FIFO entries.
package srambank_pkg;

   localparam int SRB_AW         = 8;
   localparam int SRB_DW         = 20;
   localparam int SRB_RESP_DEPTH = 2;

   // One request beat as seen on the request channel.
   typedef struct packed {
      logic              write;
      logic [SRB_AW-1:0] addr;
      logic [SRB_DW-1:0] wdata;
   } srb_req_t;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int srb_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/srambank_req_ctrl_if.sv
// srambank_req_ctrl_if
//   Request/response channel between a requester (master) and the
//   srambank request controller (slave).
//   Request : req_valid, req_ready, req_write, req_addr, req_wdata
//   Response: resp_valid, resp_ready, resp_data (read data, oldest first)
interface srambank_req_ctrl_if
   import srambank_pkg::*;
#(
   parameter int AW = SRB_AW,
   parameter int DW = SRB_DW
) ();

   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_data;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_data
   );

endinterface

// File: rtl/srambank_resp_fifo.sv
// srambank_resp_fifo
//   Circular response buffer with registered storage and no bypass: a
//   pushed word is visible at the output from the cycle after the push.
//   Pointers wrap modulo DEPTH, so non-power-of-two depths work.
//   Ports: clk, reset (async, active-high), push_i/push_data_i,
//          pop_i (only when valid_o), valid_o, pop_data_o, count_o.
module srambank_resp_fifo
   import srambank_pkg::*;
#(
   parameter int DW    = SRB_DW,
   parameter int DEPTH = SRB_RESP_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = srb_cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [DW-1:0] pop_data_o,
   output logic [CW-1:0] count_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = ptr_inc(wptr_q);
      if (pop_i)  rptr_d = ptr_inc(rptr_q);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push_i) mem_q[wptr_q] <= push_data_i;
      end
   end

   assign valid_o    = (count_q != '0);
   assign pop_data_o = mem_q[rptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/srambank_req_ctrl.sv
// srambank_req_ctrl
//   Front-end for one srambank_64x4x20_6t122 bank. Turns a valid/ready
//   request stream into single-cycle banksel/read/write strobes, captures
//   the bank's latched dataout one cycle after each read and returns it
//   through a credit-protected response FIFO. Writes return nothing.
//   Ports: clk, reset (async, active-high), bus (request/response slave),
//          ADDRESS/wd/banksel/read/write to the bank, dataout from it.
module srambank_req_ctrl
   import srambank_pkg::*;
#(
   parameter int AW         = SRB_AW,
   parameter int DW         = SRB_DW,
   parameter int RESP_DEPTH = SRB_RESP_DEPTH,
   localparam int CW        = srb_cnt_w(RESP_DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   srambank_req_ctrl_if.slave  bus,
   output logic [AW-1:0]       ADDRESS,
   output logic [DW-1:0]       wd,
   output logic                banksel,
   output logic                read,
   output logic                write,
   input  logic [DW-1:0]       dataout
);

   localparam logic [CW:0] DEPTH_C = (CW+1)'(RESP_DEPTH);

   logic          inflight_q, inflight_d;
   logic          accept;
   logic          pop;
   logic [CW-1:0] count;
   logic [CW:0]   used;

   // A read needs a slot reserved for its data: queued entries plus the
   // one possibly still in the bank. Only registered state feeds this, so
   // resp_ready never reaches req_ready combinationally.
   assign used          = {1'b0, count} + (CW+1)'(inflight_q);
   assign bus.req_ready = ~reset & (bus.req_write | (used < DEPTH_C));
   assign accept        = bus.req_valid & bus.req_ready;

   assign ADDRESS = bus.req_addr;
   assign wd      = bus.req_wdata;
   assign banksel = accept;
   assign write   = accept & bus.req_write;
   assign read    = accept & ~bus.req_write;

   // The bank latches dataout on the accepting edge; it is ours to
   // capture on the following edge.
   assign inflight_d = read;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) inflight_q <= 1'b0;
      else       inflight_q <= inflight_d;
   end

   assign pop = bus.resp_valid & bus.resp_ready;

   srambank_resp_fifo #(
      .DW    (DW),
      .DEPTH (RESP_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (inflight_q),
      .push_data_i (dataout),
      .pop_i       (pop),
      .valid_o     (bus.resp_valid),
      .pop_data_o  (bus.resp_data),
      .count_o     (count)
   );

endmodule

// File: tb/tb_srambank_req_ctrl.sv
// Integration bench: two controllers (response depth 2 and 3), each in
// front of a behavioural model of the bank.
module tb_srambank_req_ctrl;
   import srambank_pkg::*;

   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   srambank_req_ctrl_if #(.AW(SRB_AW), .DW(SRB_DW)) if2 ();
   srambank_req_ctrl_if #(.AW(SRB_AW), .DW(SRB_DW)) if3 ();

   logic [1:0]             rv, rw, rr;
   logic [1:0][SRB_AW-1:0] ra;
   logic [1:0][SRB_DW-1:0] rwd;
   logic [1:0]             rdy, vld;
   logic [1:0][SRB_DW-1:0] rsp;

   assign if2.req_valid  = rv[0];
   assign if2.req_write  = rw[0];
   assign if2.req_addr   = ra[0];
   assign if2.req_wdata  = rwd[0];
   assign if2.resp_ready = rr[0];
   assign if3.req_valid  = rv[1];
   assign if3.req_write  = rw[1];
   assign if3.req_addr   = ra[1];
   assign if3.req_wdata  = rwd[1];
   assign if3.resp_ready = rr[1];
   assign rdy = {if3.req_ready, if2.req_ready};
   assign vld = {if3.resp_valid, if2.resp_valid};
   assign rsp = {if3.resp_data, if2.resp_data};

   logic [SRB_AW-1:0] a2, a3;
   logic [SRB_DW-1:0] wd2, wd3, do2, do3;
   logic              bs2, rd2, wr2, bs3, rd3, wr3;
   logic [SRB_DW-1:0] bmem2 [256];
   logic [SRB_DW-1:0] bmem3 [256];

   // Bank models: write wins, read latches dataout, reset-independent.
   always @(posedge clk) begin
      if (bs2) begin
         if (wr2)      bmem2[a2] <= wd2;
         else if (rd2) do2 <= bmem2[a2];
      end
      if (bs3) begin
         if (wr3)      bmem3[a3] <= wd3;
         else if (rd3) do3 <= bmem3[a3];
      end
   end

   srambank_req_ctrl #(.RESP_DEPTH(2)) dut2 (
      .clk(clk), .reset(reset), .bus(if2.slave), .ADDRESS(a2), .wd(wd2),
      .banksel(bs2), .read(rd2), .write(wr2), .dataout(do2));

   srambank_req_ctrl #(.RESP_DEPTH(3)) dut3 (
      .clk(clk), .reset(reset), .bus(if3.slave), .ADDRESS(a3), .wd(wd3),
      .banksel(bs3), .read(rd3), .write(wr3), .dataout(do3));

   int checks = 0;
   int errs   = 0;
   int pops [2];
   int samepp = 0;
   int p0;
   logic [SRB_DW-1:0] exq0 [$];
   logic [SRB_DW-1:0] exq1 [$];
   logic [SRB_DW-1:0] refm0 [256];
   logic [SRB_DW-1:0] refm1 [256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic srb_req_t mkreq(input bit w, input int a, input int d);
      srb_req_t r;
      r.write = w;
      r.addr  = SRB_AW'(a);
      r.wdata = SRB_DW'(d);
      return r;
   endfunction

   // Scoreboard: expectations queued on acceptance, consumed on pop.
   always @(negedge clk) begin
      if (!reset) begin
         chk("strobe_excl2", 32'(rd2 & wr2), 32'd0);
         chk("strobe_excl3", 32'(rd3 & wr3), 32'd0);
      end
      if (vld[0] && rr[0]) begin
         if (exq0.size() == 0) chk("spurious_resp2", 32'(rsp[0]), 32'hFFFF_FFFF);
         else                  chk("resp_data2", 32'(rsp[0]), 32'(exq0.pop_front()));
         pops[0]++;
      end
      if (vld[1] && rr[1]) begin
         if (exq1.size() == 0) chk("spurious_resp3", 32'(rsp[1]), 32'hFFFF_FFFF);
         else                  chk("resp_data3", 32'(rsp[1]), 32'(exq1.pop_front()));
         pops[1]++;
      end
      if (dut2.inflight_q && vld[0] && rr[0]) samepp++;
      if (rv[0] && rdy[0]) begin
         if (rw[0]) refm0[ra[0]] = rwd[0];
         else       exq0.push_back(refm0[ra[0]]);
      end
      if (rv[1] && rdy[1]) begin
         if (rw[1]) refm1[ra[1]] = rwd[1];
         else       exq1.push_back(refm1[ra[1]]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until accepted (bounded).
   task automatic issue(input int u, input srb_req_t r, input bit rnd_rr);
      int n = 0;
      rv[u] = 1'b1;  rw[u] = r.write;  ra[u] = r.addr;  rwd[u] = r.wdata;
      forever begin
         if (rnd_rr) rr[u] = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (rdy[u]) break;
         n++;
         if (n > 40) begin
            chk("accept_timeout", 32'(n), 32'd0);
            break;
         end
         tick();
      end
      tick();
      rv[u] = 1'b0;
   endtask

   task automatic drain(input int u);
      int n = 0;
      rr[u] = 1'b1;
      while (((u == 0) ? exq0.size() : exq1.size()) != 0 || vld[u]) begin
         tick();
         n++;
         if (n > 50) begin
            chk("drain_timeout", 32'(n), 32'd0);
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   initial begin
      pops[0] = 0;  pops[1] = 0;
      rv = '0;  rw = '0;  rr = '0;  ra = '0;  rwd = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      // Requester asserting a write during reset must see no ready.
      rv[0] = 1'b1;  rw[0] = 1'b1;  ra[0] = 8'h11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready",   32'(rdy[0]), 32'd0);
      chk("reset_banksel", 32'(bs2), 32'd0);
      chk("reset_valid2",  32'(vld[0]), 32'd0);
      chk("reset_data2",   32'(rsp[0]), 32'd0);
      chk("reset_valid3",  32'(vld[1]), 32'd0);
      chk("reset_data3",   32'(rsp[1]), 32'd0);
      rv[0] = 1'b0;  rw[0] = 1'b0;
      tick();
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         issue(0, mkreq(1'b1, i, i * 3), 1'b0);
         issue(1, mkreq(1'b1, i, i * 3), 1'b0);
      end
      for (int i = 8; i < 16; i++) issue(1, mkreq(1'b1, i, i * 5 + 1), 1'b0);

      // Write then read with latency checks.
      issue(0, mkreq(1'b1, 'h3C, 'h00012), 1'b0);
      @(negedge clk);  chk("wr_no_resp_a", 32'(vld[0]), 32'd0);
      tick();
      @(negedge clk);  chk("wr_no_resp_b", 32'(vld[0]), 32'd0);
      tick();
      rr[0] = 1'b1;  rv[0] = 1'b1;  rw[0] = 1'b0;  ra[0] = 8'h3C;
      @(negedge clk);  chk("rd_ready", 32'(rdy[0]), 32'd1);
      tick();
      rv[0] = 1'b0;
      @(negedge clk);  chk("lat_n_valid", 32'(vld[0]), 32'd0);
      tick();
      @(negedge clk);
      chk("lat_n1_valid", 32'(vld[0]), 32'd1);
      chk("lat_n1_data",  32'(rsp[0]), 32'h12);
      tick();
      @(negedge clk);  chk("lat_n2_empty", 32'(vld[0]), 32'd0);
      tick();

      // Read immediately after write to the same address.
      issue(0, mkreq(1'b1, 'h3D, 'h00777), 1'b0);
      issue(0, mkreq(1'b0, 'h3D, 0), 1'b0);
      drain(0);

      // Streaming reads on the depth-3 controller.
      p0 = pops[1];
      rr[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rv[1] = 1'b1;  rw[1] = 1'b0;  ra[1] = SRB_AW'(i);
         @(negedge clk);
         chk("stream_ready", 32'(rdy[1]), 32'd1);
         if (i >= 2) chk("stream_valid", 32'(vld[1]), 32'd1);
         tick();
      end
      rv[1] = 1'b0;
      @(negedge clk);  chk("stream_tail_a", 32'(vld[1]), 32'd1);
      tick();
      @(negedge clk);  chk("stream_tail_b", 32'(vld[1]), 32'd1);
      tick();
      @(negedge clk);  chk("stream_done", 32'(vld[1]), 32'd0);
      chk("stream_pops", 32'(pops[1] - p0), 32'd8);
      tick();

      // Backpressure on the depth-2 controller.
      rr[0] = 1'b0;
      issue(0, mkreq(1'b0, 1, 0), 1'b0);
      issue(0, mkreq(1'b0, 2, 0), 1'b0);
      rv[0] = 1'b1;  rw[0] = 1'b0;  ra[0] = 8'd3;
      @(negedge clk);
      chk("bp_stall",  32'(rdy[0]), 32'd0);
      chk("bp_credit", 32'(dut2.used), 32'd2);
      tick();
      rw[0] = 1'b1;  ra[0] = 8'h50;  rwd[0] = 20'hABCDE;
      @(negedge clk);  chk("bp_write_ok", 32'(rdy[0]), 32'd1);
      tick();
      rw[0] = 1'b0;  ra[0] = 8'd3;
      @(negedge clk);  chk("bp_still_stalled", 32'(rdy[0]), 32'd0);
      tick();
      rr[0] = 1'b1;
      issue(0, mkreq(1'b0, 3, 0), 1'b0);
      drain(0);

      // Full FIFO, then continuous reads with the consumer ready.
      rr[0] = 1'b0;
      issue(0, mkreq(1'b0, 4, 0), 1'b0);
      issue(0, mkreq(1'b0, 5, 0), 1'b0);
      tick();
      @(negedge clk);  chk("se_full", 32'(dut2.count), 32'd2);
      p0 = pops[0];
      samepp = 0;
      tick();
      rr[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         issue(0, mkreq(1'b0, i % 8, 0), 1'b0);
         chk("se_credit", 32'(dut2.used <= 2), 32'd1);
      end
      drain(0);
      chk("se_pop_total", 32'(pops[0] - p0), 32'd22);
      chk("se_same_edge_seen", 32'(samepp > 0), 32'd1);

      // Reset with one entry queued and one read in flight.
      rr[0] = 1'b0;
      issue(0, mkreq(1'b0, 'h3C, 0), 1'b0);
      issue(0, mkreq(1'b0, 'h50, 0), 1'b0);
      chk("pre_rst_count", 32'(dut2.count), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_valid",    32'(vld[0]), 32'd0);
      chk("rst_count",    32'(dut2.count), 32'd0);
      chk("rst_inflight", 32'(dut2.inflight_q), 32'd0);
      exq0.delete();
      exq1.delete();
      tick();
      tick();
      reset = 1'b0;
      rr[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);  chk("post_rst_quiet", 32'(vld[0]), 32'd0);
         tick();
      end
      p0 = pops[0];
      issue(0, mkreq(1'b0, 'h3C, 0), 1'b0);
      issue(0, mkreq(1'b0, 'h50, 0), 1'b0);
      drain(0);
      chk("post_rst_pops", 32'(pops[0] - p0), 32'd2);

      // Depth-3 wrap under random consumer stalls.
      p0 = pops[1];
      for (int i = 0; i < 10; i++) issue(1, mkreq(1'b0, (i * 5 + 3) % 16, 0), 1'b1);
      drain(1);
      chk("wrap_pops",  32'(pops[1] - p0), 32'd10);
      chk("wrap_rptr",  32'(dut3.u_fifo.rptr_q), 32'd1);
      chk("wrap_wptr",  32'(dut3.u_fifo.wptr_q), 32'd1);
      chk("wrap_count", 32'(dut3.u_fifo.count_q), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
